pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RV32IM pipeline. It drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences the multi-cycle divider, resolving:
- memory busywait freezes
- divider occupancy
- taken branches/jumps
- load-use hazards

It sits beside the datapath; all of its outputs are combinational functions of its inputs and one small registered FSM.

## Interface
- DIV_CYCLES, 32, cycles the divider needs from div_start to a valid result (≥2)
- clk  in  1  pipeline clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2
- ex_dest_addr  in  5  destination register of the instruction in EX
- ex_reg_write_en  in  1  EX instruction writes the register file
- ex_mem_read  in  4  EX memory-read code; load when bit 3 = 1
- ex_is_div  in  1  EX instruction is DIV/DIVU/REM/REMU
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- imem_busywait, dmem_busywait  in  1 each  instruction/data memory not ready
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold register contents
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all control fields 0) on next edge
- div_start  out  1  one-cycle pulse launching the divider
- div_done  out  1  divider result valid; EX/MEM may capture it
- div_busy  out  1  FSM not IDLE

## Operation
- FSM states:
  - IDLE: no division in flight.
  - RUN: down-counter cnt of width clog2(DIV_CYCLES) is active.
  - DONE: result is valid.
- IDLE→RUN when ex_is_div=1 and dmem_busywait=0. In that cycle div_start=1 and cnt loads DIV_CYCLES-1.
- RUN: cnt decrements every cycle, regardless of dmem_busywait. At cnt=0 the next state is DONE.
- DONE: div_done=1. DONE→IDLE when dmem_busywait=0; otherwise it stays in DONE, holding div_done.
- Load-use hazard (lu) = ex_mem_read[3] & ex_reg_write_en & ex_dest_addr≠0 & ((id_rs1_used & id_rs1_addr=ex_dest_addr) | (id_rs2_used & id_rs2_addr=ex_dest_addr)).
- Output priority, highest first; anything not asserted is 0:
  1. dmem_busywait=1: all five stalls =1, no flushes. This holds in every FSM state.
  2. FSM in IDLE with ex_is_div=1, or FSM in RUN:
     - pc_stall, if_id_stall and id_ex_stall =1.
     - ex_mem_flush=1 (a bubble enters MEM each cycle).
     - ex_branch_taken and lu are ignored.
  3. ex_branch_taken=1: if_id_flush=1 and id_ex_flush=1. pc_stall=0 even when imem_busywait=1, so the redirect is taken.
  4. lu=1: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  5. imem_busywait=1: pc_stall=1 and if_id_flush=1 (a bubble enters ID).
- In DONE with dmem_busywait=0: no stalls or flushes from the divider. The instruction in EX proceeds with the divider result, and rules 3–5 apply normally.
- Reset: state←IDLE, cnt←0. While rst=1 every output is forced to 0.

## Timing
- Division occupies EX for exactly DIV_CYCLES+1 cycles: the start cycle, DIV_CYCLES-1 RUN cycles, then DONE.
- The instruction after a DIV enters EX on the edge that ends DONE.
- A load-use stall costs 1 cycle: the bubble is inserted into ID/EX and the dependent instruction re-evaluates next cycle with the load in MEM.
- Branch penalty is 2 bubbles, both flushed on the same edge.
- Flush and stall of the same register are never asserted together.
- rst asserted mid-division aborts it: the FSM is in IDLE on the next edge and div_done is never pulsed for the aborted operation.
- ex_dest_addr=0 never causes a load-use stall.

## Test plan
- Load-use: EX = LW x5 (ex_mem_read=4'b1010, dest 5); ID = ADD x6,x5,x1 (rs1_used=1). Required: exactly 1 cycle with pc_stall=if_id_stall=id_ex_flush=1, then 0.
- Divide with DIV_CYCLES=4, ex_is_div=1 from IDLE:
  - div_start pulses once.
  - div_busy=1 for 5 cycles.
  - pc/if_id/id_ex stall =1 for 4 cycles.
  - div_done=1 in the 5th cycle with all stalls 0.
- dmem_busywait held 3 cycles during DONE: all stalls =1, div_done stays 1 for 4 cycles, then the FSM is in IDLE.
- ex_branch_taken=1 together with lu=1 and imem_busywait=1: if_id_flush=id_ex_flush=1, pc_stall=0, if_id_stall=0.
- Rule 1 over rule 3: dmem_busywait=1 and ex_branch_taken=1 together: all stalls 1, all flushes 0.
- Reset mid-division: rst=1 pulsed in the 2nd RUN cycle. Required: all outputs 0 during rst, div_busy=0 after, no div_done pulse.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush controller for the five-stage RV32IM pipeline.
//                Resolves memory busywait freezes, divider occupancy, taken
//                branches/jumps and load-use hazards; sequences the
//                multi-cycle divider with a small IDLE/RUN/DONE FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_dest_addr,
  input  logic       ex_reg_write_en,
  input  logic [3:0] ex_mem_read,
  input  logic       ex_is_div,
  input  logic       ex_branch_taken,
  input  logic       imem_busywait,
  input  logic       dmem_busywait,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       mem_wb_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       div_start,
  output logic       div_done,
  output logic       div_busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CW-1:0] c_CNT_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_launch;
  logic          w_lu;
  logic          w_unused_mem_code;

  // Only the load flag of the memory-read code matters here.
  assign w_unused_mem_code = ^ex_mem_read[2:0];

  // A division launches from IDLE only once the data memory is not freezing EX.
  assign w_launch = (r_state == c_IDLE) && ex_is_div && !dmem_busywait;

  // Load-use: ID reads the register a load in EX is about to write (x0 exempt).
  assign w_lu = ex_mem_read[3] && ex_reg_write_en && (ex_dest_addr != 5'd0) &&
                ((id_rs1_used && (id_rs1_addr == ex_dest_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_dest_addr)));

  // State register: divider FSM and its cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: the counter is loaded at launch and counts down in RUN
  // independently of memory freezes; DONE is entered as it reaches zero, so
  // RUN lasts DIV_CYCLES-1 cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_launch) begin
          w_state_next = c_RUN;
          w_cnt_next   = c_CNT_LOAD;
        end
      end
      c_RUN: begin
        w_cnt_next = r_cnt - c_CNT_ONE;
        if (r_cnt <= c_CNT_ONE) begin
          w_state_next = c_DONE;
        end
      end
      c_DONE: begin
        if (!dmem_busywait) begin
          w_state_next = c_IDLE;
        end
      end
      default: begin
        w_state_next = c_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic: prioritised stall/flush resolution; everything is held at 0
  // while reset is asserted.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    div_start    = 1'b0;
    div_done     = 1'b0;
    div_busy     = 1'b0;
    if (!rst) begin
      div_start = w_launch;
      div_done  = (r_state == c_DONE);
      // Busy covers the launch cycle too, so the occupancy window is the
      // full DIV_CYCLES+1 cycles the division holds EX.
      div_busy  = (r_state != c_IDLE) || w_launch;
      if (dmem_busywait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (((r_state == c_IDLE) && ex_is_div) || (r_state == c_RUN)) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (imem_busywait) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  // Expected vector layout:
  // {pc,if_id,id_ex,ex_mem,mem_wb stall}_{if_id,id_ex,ex_mem flush}_{start,done,busy}
  localparam logic [10:0] c_ZERO   = 11'b00000_000_000;
  localparam logic [10:0] c_LU     = 11'b11000_010_000;
  localparam logic [10:0] c_BRANCH = 11'b00000_110_000;
  localparam logic [10:0] c_IMEM   = 11'b10000_100_000;
  localparam logic [10:0] c_DMEM   = 11'b11111_000_000;
  localparam logic [10:0] c_DSTART = 11'b11100_001_101;
  localparam logic [10:0] c_DRUN   = 11'b11100_001_001;
  localparam logic [10:0] c_DDONE  = 11'b00000_000_011;
  localparam logic [10:0] c_DDMEM  = 11'b11111_000_011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_dest_addr;
  logic       id_rs1_used, id_rs2_used, ex_reg_write_en;
  logic [3:0] ex_mem_read;
  logic       ex_is_div, ex_branch_taken, imem_busywait, dmem_busywait;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic       div_start, div_done, div_busy;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_dest_addr(ex_dest_addr), .ex_reg_write_en(ex_reg_write_en),
    .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div),
    .ex_branch_taken(ex_branch_taken),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .div_start(div_start), .div_done(div_done), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic clr_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_dest_addr = 5'd0; ex_reg_write_en = 1'b0; ex_mem_read = 4'd0;
    ex_is_div = 1'b0; ex_branch_taken = 1'b0; imem_busywait = 1'b0; dmem_busywait = 1'b0;
  endtask

  // Advance one clock, land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle on the current inputs, then compare.
  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    #1;
    got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, div_start, div_done, div_busy};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic set_load_x5();
    ex_mem_read = 4'b1010; ex_reg_write_en = 1'b1; ex_dest_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1'b1; id_rs2_addr = 5'd1; id_rs2_used = 1'b1;
  endtask

  initial begin
    clr_inputs();
    rst = 1'b1;
    tick(); tick();
    // Outputs forced low during reset even with active requests.
    dmem_busywait = 1'b1; ex_is_div = 1'b1;
    check("reset_forced_zero", c_ZERO);
    clr_inputs();
    tick();
    rst = 1'b0;
    check("idle_after_reset", c_ZERO);

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID -> one stall cycle.
    tick();
    set_load_x5();
    check("loaduse_stall", c_LU);
    tick();
    clr_inputs();                      // load moved to MEM
    id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    check("loaduse_released", c_ZERO);

    // Destination x0 never stalls.
    set_load_x5();
    ex_dest_addr = 5'd0; id_rs1_addr = 5'd0;
    check("loaduse_x0", c_ZERO);
    // Match on rs2 only counts when rs2 is used.
    set_load_x5();
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd5; id_rs2_used = 1'b0;
    check("loaduse_rs2_unused", c_ZERO);
    id_rs2_used = 1'b1;
    check("loaduse_rs2_used", c_LU);
    // Not a load: no hazard.
    ex_mem_read = 4'b0010;
    check("loaduse_not_load", c_ZERO);

    // Branch beats load-use and imem busywait.
    set_load_x5();
    ex_branch_taken = 1'b1; imem_busywait = 1'b1;
    check("branch_over_lu_imem", c_BRANCH);
    // dmem busywait beats branch.
    dmem_busywait = 1'b1;
    check("dmem_over_branch", c_DMEM);
    clr_inputs();
    imem_busywait = 1'b1;
    check("imem_only", c_IMEM);
    clr_inputs();

    // Divide, DIV_CYCLES=4: start + 3 RUN + DONE.
    tick();
    ex_is_div = 1'b1;
    check("div_start", c_DSTART);
    tick(); check("div_run1", c_DRUN);
    ex_branch_taken = 1'b1; set_load_x5();   // ignored while dividing
    tick(); check("div_run2_ignore", c_DRUN);
    clr_inputs(); ex_is_div = 1'b1;
    tick(); check("div_run3", c_DRUN);
    tick(); check("div_done", c_DDONE);
    tick(); clr_inputs();
    check("div_back_idle", c_ZERO);

    // Divide held off by dmem busywait, then DONE extended by busywait.
    ex_is_div = 1'b1; dmem_busywait = 1'b1;
    check("div_dmem_holdoff", c_DMEM);
    dmem_busywait = 1'b0;
    check("div2_start", c_DSTART);
    tick(); check("div2_run1", c_DRUN);
    tick(); check("div2_run2", c_DRUN);
    tick(); check("div2_run3", c_DRUN);
    tick(); dmem_busywait = 1'b1;
    check("div2_done_dmem1", c_DDMEM);
    tick(); check("div2_done_dmem2", c_DDMEM);
    tick(); check("div2_done_dmem3", c_DDMEM);
    tick(); dmem_busywait = 1'b0;
    check("div2_done_final", c_DDONE);
    tick(); clr_inputs();
    check("div2_back_idle", c_ZERO);

    // Reset in the 2nd RUN cycle aborts the division.
    ex_is_div = 1'b1;
    check("div3_start", c_DSTART);
    tick(); check("div3_run1", c_DRUN);
    tick(); rst = 1'b1;
    check("div3_rst_zero", c_ZERO);
    tick(); rst = 1'b0; clr_inputs();
    check("div3_aborted_idle", c_ZERO);
    tick(); check("div3_no_done_a", c_ZERO);
    tick(); check("div3_no_done_b", c_ZERO);
    tick(); check("div3_no_done_c", c_ZERO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
